// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: latches four BCD digits and scans them onto a 4-digit common 7-seg display (optional SEG7_LZ_BLANK_EN leading-zero blanking)
module seg7_scan_driver #(
  parameter int DIV_MAX   = 49999,
  parameter int CNT_W     = 16,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld,
  input  logic [15:0] bcd_in,
  output logic        busy,
  output logic [3:0]  an,
  output logic [6:0]  seg
);
  localparam logic [CNT_W-1:0] TC = CNT_W'(DIV_MAX);
  localparam logic [CNT_W-1:0] BL = CNT_W'(BLANK_CYC);
  logic [CNT_W-1:0] div_cnt;
  logic [1:0]       sel;
  logic [15:0]      disp, shadow;
  logic             wrap, fb, blank;
  logic [3:0]       digit;
  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction
  assign wrap  = div_cnt == TC;
  assign fb    = wrap && sel == 2'd3;
  assign digit = disp[{sel, 2'b00} +: 4];
`ifdef SEG7_LZ_BLANK_EN
  assign blank = sel == 2'd3 ? disp[15:12] == 4'd0 :
                 sel == 2'd2 ? disp[15:8] == 8'd0 :
                 sel == 2'd1 ? disp[15:4] == 12'd0 : 1'b0;
`else
  assign blank = 1'b0;
`endif
  // refresh divider and digit scan pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      sel     <= '0;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + 1'b1;
      if (wrap) sel <= sel + 2'd1;
    end
  end
  // load handshake: new values only reach disp at the frame boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      disp   <= '0;
      shadow <= '0;
      busy   <= 1'b0;
    end else if (ld) begin
      shadow <= bcd_in;
      busy   <= !fb;
      if (fb) disp <= bcd_in;
    end else if (fb && busy) begin
      disp <= shadow;
      busy <= 1'b0;
    end
  end
  // registered anode/segment drive with anti-ghost blanking at slot start
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 4'hF;
      seg <= 7'h7F;
    end else begin
      an  <= div_cnt < BL ? 4'hF : ~(4'b0001 << sel);
      seg <= blank ? 7'h7F : ~dec(digit);
    end
  end
endmodule
